logistic_bank: RTL and testbench

LOGISTIC_BANK -- requirements
Module: logistic_bank

---
 rtl/logistic_bank_if.sv | 31 +++
 rtl/logistic_bank.sv | 144 ++++++++++++++
 tb/tb_logistic_bank.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/logistic_bank_if.sv
// logistic_bank_if: control, seed-write and read-back bundle for logistic_bank.
//   master (bench/host) drives: start, mu, times, seed_we, seed_ch, seed_data, rd_ch
//   slave  (logistic_bank) drives: rd_data, busy, done, converged
interface logistic_bank_if #(
  parameter int unsigned NCH = 6,
  parameter int unsigned XW  = 17,
  parameter int unsigned MW  = 18,
  parameter int unsigned TW  = 10
);
  logic           start;
  logic [MW-1:0]  mu;
  logic [TW-1:0]  times;
  logic           seed_we;
  logic [3:0]     seed_ch;
  logic [XW-1:0]  seed_data;
  logic [3:0]     rd_ch;
  logic [XW-1:0]  rd_data;
  logic           busy;
  logic           done;
  logic [NCH-1:0] converged;

  modport master (
    output start, mu, times, seed_we, seed_ch, seed_data, rd_ch,
    input  rd_data, busy, done, converged
  );

  modport slave (
    input  start, mu, times, seed_we, seed_ch, seed_data, rd_ch,
    output rd_data, busy, done, converged
  );
endinterface

// File: rtl/logistic_bank.sv
// logistic_bank: bank of NCH logistic-map channels x <- mu*x*(1-x) sharing one
// map datapath, one channel per RUN cycle in order 0..NCH-1, for `times` passes.
//   CLK  : clock, rising edge
//   RST  : asynchronous active-low reset (channels return to their seeds)
//   bus  : logistic_bank_if.slave
//          start/mu/times   - run request, mu and times sampled on accepted start
//          seed_we/ch/data  - seed write, honoured only outside RUN
//          rd_ch/rd_data    - registered read-back, one cycle latency
//          busy/done        - RUN / DONE state indication
//          converged        - per-channel sticky fixed-point flags
// Optional feature: define LOGISTIC_BANK_CONVERGE_EN to build the fixed-point
// detection; otherwise converged is tied to zero.
module logistic_bank #(
  parameter int unsigned NCH       = 6,
  parameter int unsigned XW        = 17,
  parameter int unsigned MW        = 18,
  parameter int unsigned TW        = 10,
  parameter int unsigned SEED0     = 2 ** (XW - 1),
  parameter int unsigned SEED_STEP = 2
) (
  input logic             CLK,
  input logic             RST,
  logistic_bank_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] LAST = 4'(NCH - 1);
  localparam logic [4:0] NCH5 = 5'(NCH);

  function automatic logic [XW-1:0] seed_of(input int unsigned i);
    return XW'(SEED0 + i * SEED_STEP);
  endfunction

  state_t         state_q, state_d;
  logic [3:0]     ptr_q;
  logic [TW-1:0]  pass_q;
  logic [MW-1:0]  mu_q;
  logic [TW-1:0]  times_q;
  logic [XW-1:0]  rd_q;
  // Sized to the full 4-bit channel index space so every select is exact;
  // entries at NCH and above stay at zero and are never read out.
  logic [XW-1:0]  x [16];

  logic           accept;
  logic           upd;
  logic           seed_ok;
  logic [XW-1:0]  x_cur;
  logic [XW:0]    comp;
  logic [2*XW:0]  t_wide;
  logic [MW+2*XW:0] y_wide;
  logic [XW-1:0]  y;

  // Control
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    upd     = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = (bus.times != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        upd = 1'b1;
        if (ptr_q == LAST && pass_q == times_q - TW'(1)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  assign seed_ok = (state_q != RUN) && bus.seed_we && ({1'b0, bus.seed_ch} < NCH5);

  // Shared map datapath; widened so nothing is lost before either shift.
  always_comb begin
    x_cur  = x[ptr_q];
    comp   = {1'b1, {XW{1'b0}}} - {1'b0, x_cur};
    t_wide = ((2*XW+1)'(x_cur) * (2*XW+1)'(comp)) >> XW;
    y_wide = ((MW+2*XW+1)'(mu_q) * (MW+2*XW+1)'(t_wide)) >> (MW - 2);
    y      = XW'(y_wide);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ptr_q   <= '0;
      pass_q  <= '0;
      mu_q    <= '0;
      times_q <= '0;
      rd_q    <= '0;
      for (int unsigned i = 0; i < 16; i++) x[i] <= (i < NCH) ? seed_of(i) : '0;
    end else begin
      if (accept) begin
        mu_q    <= bus.mu;
        times_q <= bus.times;
        ptr_q   <= '0;
        pass_q  <= '0;
      end else if (upd) begin
        if (ptr_q == LAST) begin
          ptr_q  <= '0;
          pass_q <= pass_q + TW'(1);
        end else begin
          ptr_q <= ptr_q + 4'd1;
        end
      end
      for (int unsigned i = 0; i < NCH; i++) begin
        if (seed_ok && bus.seed_ch == 4'(i))  x[i] <= bus.seed_data;
        else if (upd && ptr_q == 4'(i))       x[i] <= y;
      end
      rd_q <= ({1'b0, bus.rd_ch} < NCH5) ? x[bus.rd_ch] : '0;
    end
  end

`ifdef LOGISTIC_BANK_CONVERGE_EN
  logic [NCH-1:0] conv_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      conv_q <= '0;
    end else if (accept) begin
      conv_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (upd && ptr_q == 4'(i) && y == x_cur) conv_q[i] <= 1'b1;
      end
    end
  end

  assign bus.converged = conv_q;
`else
  assign bus.converged = '0;
`endif

  assign bus.busy    = (state_q == RUN);
  assign bus.done    = (state_q == DONE);
  assign bus.rd_data = rd_q;

endmodule

// File: tb/tb_logistic_bank.sv
// Scoreboard bench for logistic_bank: stimulus pushes expected run results and
// read-back values into queues; two monitors pop and compare when the DUT
// presents done (rising) or a read result.
module tb_logistic_bank;
  localparam int NCH = 6;
  localparam int XW  = 17;
  localparam int MW  = 18;
  localparam int TW  = 10;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  logistic_bank_if #(.NCH(NCH), .XW(XW), .MW(MW), .TW(TW)) bus ();

  logistic_bank #(.NCH(NCH), .XW(XW), .MW(MW), .TW(TW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    int             cycles;
    logic [NCH-1:0] conv;
  } run_exp_t;

  typedef struct {
    int             ch;
    logic [XW-1:0]  val;
  } rd_exp_t;

  int checks   = 0;
  int failures = 0;

  longint         xm [NCH];
  logic [NCH-1:0] conv_m;
  run_exp_t       run_q [$];
  rd_exp_t        rd_q  [$];
  logic           rd_req = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference map from plain integer arithmetic.
  function automatic longint fmap(input longint x, input longint m);
    longint one, t;
    one = longint'(1) << XW;
    t   = (x * (one - x)) >> XW;
    return ((m * t) >> (MW - 2)) % one;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) xm[i] = ((longint'(1) << (XW - 1)) + 2 * i) % (longint'(1) << XW);
    conv_m = '0;
  endfunction

  function automatic void model_run(input longint m, input int t);
    run_exp_t e;
    longint y;
    conv_m = '0;
    for (int p = 0; p < t; p++) begin
      for (int c = 0; c < NCH; c++) begin
        y = fmap(xm[c], m);
        if (y == xm[c]) conv_m[c] = 1'b1;
        xm[c] = y;
      end
    end
    e.cycles = t * NCH;
`ifdef LOGISTIC_BANK_CONVERGE_EN
    e.conv = conv_m;
`else
    e.conv = '0;
`endif
    run_q.push_back(e);
  endfunction

  // Read-back monitor: a request issued before a rising edge is answered
  // after that edge.
  initial begin
    forever begin
      logic cap;
      rd_exp_t e;
      @(posedge CLK);
      cap = rd_req;
      @(negedge CLK);
      if (cap && RST) begin
        if (rd_q.size() == 0) begin
          check("rd_queue_underflow", 1, 0);
        end else begin
          e = rd_q.pop_front();
          check($sformatf("rd_data_ch%0d", e.ch), bus.rd_data, e.val);
        end
      end
    end
  end

  // Run monitor: counts busy cycles and checks each completed run on done rising.
  int   busy_cnt  = 0;
  logic done_prev = 1'b0;
  initial begin
    forever begin
      run_exp_t e;
      @(negedge CLK);
      if (!RST) begin
        busy_cnt  = 0;
        done_prev = 1'b0;
      end else begin
        if (bus.busy) busy_cnt++;
        if (bus.done && !done_prev) begin
          if (run_q.size() == 0) begin
            check("run_queue_underflow", 1, 0);
          end else begin
            e = run_q.pop_front();
            check("busy_cycles", busy_cnt, e.cycles);
            check("converged", bus.converged, e.conv);
          end
          busy_cnt = 0;
        end
        done_prev = bus.done;
      end
    end
  end

  task automatic do_reset();
    RST           = 1'b0;
    bus.start     = 1'b0;
    bus.seed_we   = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    model_reset();
  endtask

  task automatic read_ch(input int ch);
    rd_exp_t e;
    @(posedge CLK);
    #1;
    bus.rd_ch = 4'(ch);
    rd_req    = 1'b1;
    e.ch  = ch;
    e.val = (ch < NCH) ? XW'(xm[ch]) : '0;
    rd_q.push_back(e);
    @(posedge CLK);
    #1;
    rd_req = 1'b0;
  endtask

  task automatic read_all();
    for (int c = 0; c < NCH; c++) read_ch(c);
  endtask

  task automatic seed(input int ch, input longint data);
    @(posedge CLK);
    #1;
    bus.seed_we   = 1'b1;
    bus.seed_ch   = 4'(ch);
    bus.seed_data = XW'(data);
    @(posedge CLK);
    #1;
    bus.seed_we = 1'b0;
    if (ch < NCH) xm[ch] = data;
  endtask

  // One-cycle start pulse, optionally with a simultaneous seed write.
  task automatic start_pulse(input longint m, input int t, input bit push,
                             input bit sw, input int sch, input longint sd);
    if (push) begin
      if (sw && sch < NCH) xm[sch] = sd;
      model_run(m, t);
    end
    @(posedge CLK);
    #1;
    bus.start     = 1'b1;
    bus.mu        = MW'(m);
    bus.times     = TW'(t);
    bus.seed_we   = sw;
    bus.seed_ch   = 4'(sch);
    bus.seed_data = XW'(sd);
    @(posedge CLK);
    #1;
    bus.start   = 1'b0;
    bus.seed_we = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int n;
    n = 0;
    while (!bus.done && n < maxc) begin
      @(negedge CLK);
      n++;
    end
    if (!bus.done) check("done_timeout", 0, 1);
    @(negedge CLK);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.mu        = '0;
    bus.times     = '0;
    bus.seed_we   = 1'b0;
    bus.seed_ch   = '0;
    bus.seed_data = '0;
    bus.rd_ch     = '0;
    model_reset();

    // Reset state and seed values
    do_reset();
    @(negedge CLK);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_converged", bus.converged, 0);
    read_all();
    read_ch(7);

    // times = 0 from IDLE: immediate done, nothing updated
    start_pulse(0, 0, 1'b1, 1'b0, 0, 0);
    check("zero_times_done", bus.done, 1);
    check("zero_times_busy", bus.busy, 0);
    read_all();

    // Fixed point at x = 0.5, mu = 2.0
    seed(0, 'h10000);
    start_pulse('h20000, 1, 1'b1, 1'b0, 0, 0);
    wait_done(200);
    read_ch(0);

    // Near-maximum mu drives 0.5 to nearly 1.0
    seed(1, 'h10000);
    start_pulse('h3FFFF, 1, 1'b1, 1'b0, 0, 0);
    wait_done(200);
    read_ch(1);
    read_all();

    // Start and seed write during RUN are ignored
    start_pulse('h38000, 3, 1'b1, 1'b0, 0, 0);
    repeat (3) begin
      @(posedge CLK);
      #1;
    end
    bus.mu        = '1;
    bus.times     = TW'(1);
    bus.start     = 1'b1;
    bus.seed_we   = 1'b1;
    bus.seed_ch   = 4'd0;
    bus.seed_data = '0;
    @(posedge CLK);
    #1;
    bus.start   = 1'b0;
    bus.seed_we = 1'b0;
    wait_done(200);
    read_all();

    // Reset in the middle of a run
    start_pulse('h30000, 3, 1'b0, 1'b0, 0, 0);
    repeat (4) begin
      @(posedge CLK);
      #1;
    end
    RST = 1'b0;
    #2;
    check("midrun_reset_busy", bus.busy, 0);
    check("midrun_reset_done", bus.done, 0);
    check("midrun_reset_rd", bus.rd_data, 0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    model_reset();
    read_all();

    // Randomized runs, including seed+start in the same cycle and
    // out-of-range seed writes / reads
    for (int k = 0; k < 10; k++) begin
      longint m, sd;
      int     t, sch, sel;
      for (int s = 0; s < 2; s++) begin
        sel = $urandom_range(0, 3);
        sd  = (sel == 0) ? 0 : (sel == 1) ? 'h10000 : $urandom_range(0, (1 << XW) - 1);
        seed($urandom_range(0, 9), sd);
      end
      sel = $urandom_range(0, 3);
      m   = (sel == 0) ? 'h20000 : (sel == 1) ? 0 : $urandom_range(0, (1 << MW) - 1);
      t   = $urandom_range(1, 3);
      sch = $urandom_range(0, 7);
      sd  = $urandom_range(0, (1 << XW) - 1);
      start_pulse(m, t, 1'b1, ($urandom_range(0, 1) == 1), sch, sd);
      wait_done(4 * NCH + 20);
      for (int r = 0; r < 3; r++) read_ch($urandom_range(0, 7));
    end

    repeat (3) begin
      @(posedge CLK);
      #1;
    end
    check("run_queue_drained", run_q.size(), 0);
    check("rd_queue_drained", rd_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

endmodule
